// File: rtl/cart_nav_controller.sv
// Bump-and-steer cart navigator: debounced bumpers, light-seeking cruise, timed escape manoeuvres.
// Optional escape behaviour (BACKUP/SPIN/PUSH) is enabled by defining CART_NAV_ESCAPE_EN.
module cart_nav_controller #(
  parameter int SENSOR_W        = 3,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int BACKUP_CYCLES   = 8,
  parameter int TURN_CYCLES     = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SENSOR_W-1:0] ls,
  input  logic [SENSOR_W-1:0] rs,
  input  logic                lb,
  input  logic                rb,
  input  logic                fb,
  input  logic                bb,
  output logic [2:0]          lwa,
  output logic [2:0]          rwa,
  output logic [2:0]          nav_state,
  output logic                bump_evt
);

  localparam int MAX_DUR = (BACKUP_CYCLES > TURN_CYCLES) ? BACKUP_CYCLES : TURN_CYCLES;
  localparam int DUR_W   = $clog2(MAX_DUR + 1);
  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [2:0] WHL_REV  = 3'b100;
  localparam logic [2:0] WHL_FWD  = 3'b010;
  localparam logic [2:0] WHL_STOP = 3'b001;

  typedef enum logic [2:0] {
    S_CRUISE = 3'd0,
    S_BACKUP = 3'd1,
    S_SPIN   = 3'd2,
    S_PUSH   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t           state, state_n;
  logic [DUR_W-1:0] dur_cnt, dur_n;
  logic             spin_right, spin_right_n;
  logic [2:0]       lwa_n, rwa_n;
  logic             bump_n;

  // Bumper index order: 0 = left, 1 = right, 2 = front, 3 = back.
  logic [3:0]      btn_n;
  logic [DB_W-1:0] db_cnt [4];
  logic [3:0]      pressed;
  logic            halt_c, any_p;

  assign btn_n = {bb, fb, rb, lb};

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (reset || btn_n[i]) begin
        db_cnt[i] <= '0;
      end else if (db_cnt[i] != DB_W'(DEBOUNCE_CYCLES)) begin
        db_cnt[i] <= db_cnt[i] + 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pressed[i] = (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES));
    end
  end

  assign halt_c = (pressed[2] & pressed[3]) | (pressed[0] & pressed[1]);
  assign any_p  = |pressed;

  always_comb begin
    state_n      = state;
    spin_right_n = spin_right;
    case (state)
      S_CRUISE: begin
`ifdef CART_NAV_ESCAPE_EN
        if (halt_c) begin
          state_n = S_HALT;
        end else if (pressed[2] | pressed[0] | pressed[1]) begin
          state_n      = S_BACKUP;
          // Left bump spins right, right bump spins left, front-only spins right.
          spin_right_n = pressed[0] | ~pressed[1];
        end else if (pressed[3]) begin
          state_n = S_PUSH;
        end
`else
        if (any_p) state_n = S_HALT;
`endif
      end
      S_BACKUP: begin
        if (halt_c)                                   state_n = S_HALT;
        else if (dur_cnt == DUR_W'(BACKUP_CYCLES - 1)) state_n = S_SPIN;
      end
      S_SPIN: begin
        if (halt_c)                                 state_n = S_HALT;
        else if (dur_cnt == DUR_W'(TURN_CYCLES - 1)) state_n = S_CRUISE;
      end
      S_PUSH: begin
        if (halt_c)                                   state_n = S_HALT;
        else if (dur_cnt == DUR_W'(BACKUP_CYCLES - 1)) state_n = S_CRUISE;
      end
      S_HALT: begin
        if (!any_p) state_n = S_CRUISE;
      end
      default: state_n = S_CRUISE;
    endcase
  end

  // Duration counter only advances in timed states, so it cannot wrap while idling.
  always_comb begin
    dur_n = dur_cnt;
    if (state_n != state) begin
      dur_n = '0;
    end else if (state == S_BACKUP || state == S_SPIN || state == S_PUSH) begin
      dur_n = dur_cnt + 1'b1;
    end
  end

  // Wheel outputs are a function of the state being entered, so they move with the state.
  always_comb begin
    lwa_n = WHL_STOP;
    rwa_n = WHL_STOP;
    case (state_n)
      S_CRUISE: begin
        if (ls > rs) begin
          lwa_n = WHL_STOP; rwa_n = WHL_FWD;
        end else if (rs > ls) begin
          lwa_n = WHL_FWD;  rwa_n = WHL_STOP;
        end else if (ls != '0) begin
          lwa_n = WHL_FWD;  rwa_n = WHL_FWD;
        end
      end
      S_BACKUP: begin
        lwa_n = WHL_REV; rwa_n = WHL_REV;
      end
      S_SPIN: begin
        if (spin_right) begin
          lwa_n = WHL_FWD; rwa_n = WHL_REV;
        end else begin
          lwa_n = WHL_REV; rwa_n = WHL_FWD;
        end
      end
      S_PUSH: begin
        lwa_n = WHL_FWD; rwa_n = WHL_FWD;
      end
      default: begin
        lwa_n = WHL_STOP; rwa_n = WHL_STOP;
      end
    endcase
  end

  assign bump_n = (state_n != state) &&
                  (state_n == S_BACKUP || state_n == S_PUSH || state_n == S_HALT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_CRUISE;
      dur_cnt    <= '0;
      spin_right <= 1'b1;
      lwa        <= WHL_STOP;
      rwa        <= WHL_STOP;
      bump_evt   <= 1'b0;
    end else begin
      state      <= state_n;
      dur_cnt    <= dur_n;
      spin_right <= spin_right_n;
      lwa        <= lwa_n;
      rwa        <= rwa_n;
      bump_evt   <= bump_n;
    end
  end

  assign nav_state = state;

endmodule

// File: doc/cart_nav_controller.md
CART_NAV_CONTROLLER -- requirements
Module: cart_nav_controller

Interface
REQ-001 SHALL have parameter SENSOR_W, default 3: width of each light-sensor input.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive low samples needed to accept a bumper press (range 1..255).
REQ-003 SHALL have parameter BACKUP_CYCLES, default 8: duration of the BACKUP and PUSH states (range 1..65535).
REQ-004 SHALL have parameter TURN_CYCLES, default 8: duration of the SPIN state (range 1..65535).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have ports ls and rs, input, SENSOR_W bits each: left and right sensor magnitudes, unsigned.
REQ-008 SHALL have ports lb, rb, fb and bb, input, 1 bit each: left, right, front and back bumpers, active-low (0 = pressed).
REQ-009 SHALL have ports lwa and rwa, output, 3 bits each: left and right wheel actions, with 100 = reverse, 010 = forward and 001 = stop.
REQ-010 SHALL have port nav_state, output, 3 bits: CRUISE=0, BACKUP=1, SPIN=2, PUSH=3, HALT=4.
REQ-011 SHALL have port bump_evt, output, 1 bit: one-cycle pulse on every entry to BACKUP, PUSH or HALT.

Function
REQ-012 SHALL debounce each bumper with its own saturating counter: count up while sampled low, clear on any high sample; the debounced "pressed" flag is 1 while the count equals DEBOUNCE_CYCLES.
REQ-013 SHALL register all outputs; lwa, rwa and nav_state SHALL change on the same edge as the state register.
REQ-014 In CRUISE with no debounced press, the block SHALL set lwa/rwa one cycle after the sensors are sampled, as follows:
- ls>rs: lwa=001, rwa=010 (turn left).
- rs>ls: lwa=010, rwa=001 (turn right).
- ls==rs!=0: both 010.
- ls==rs==0: both 001.
REQ-015 SHALL apply CRUISE bump transitions with this priority:
- (fb&bb) or (lb&rb) pressed -> HALT.
- else fb, lb or rb pressed -> BACKUP.
- else bb -> PUSH.
REQ-016 On entry to BACKUP, the block SHALL latch the spin direction: lb -> spin right; else rb -> spin left; else (fb only) spin right.
REQ-017 In BACKUP, both wheels SHALL be 100 for exactly BACKUP_CYCLES cycles, after which the block goes to SPIN.
REQ-018 In SPIN, spin right SHALL be lwa=010, rwa=100, and spin left SHALL be lwa=100, rwa=010, held for exactly TURN_CYCLES cycles, after which the block goes to CRUISE.
REQ-019 In PUSH, both wheels SHALL be 010 for BACKUP_CYCLES cycles, after which the block goes to CRUISE.
REQ-020 In BACKUP, SPIN and PUSH, new single presses SHALL be ignored; a HALT condition (REQ-015) SHALL preempt to HALT on the next edge.
REQ-021 In HALT, both wheels SHALL be 001, and the block SHALL stay there until all four debounced flags are 0, then go to CRUISE.
REQ-022 The duration counter SHALL be ceil(log2(max(BACKUP_CYCLES,TURN_CYCLES)+1)) bits wide, SHALL load 0 on every state entry, and SHALL never wrap.
REQ-023 bump_evt SHALL be 1 only in the first cycle of BACKUP, PUSH or HALT.

Reset
REQ-024 While reset=1, the block SHALL force: state CRUISE, lwa=rwa=001, nav_state=0, bump_evt=0, all debounce counters 0, duration counter 0, spin direction right.
REQ-025 Reset asserted mid-BACKUP, SPIN, PUSH or HALT SHALL abandon the manoeuvre with no residual count; the first post-reset CRUISE decision SHALL use the sensors sampled in the first cycle after reset deasserts.

Configuration
REQ-026 Macro CART_NAV_ESCAPE_EN SHALL control the escape behaviour:
- Defined: behaviour exactly as REQ-015..REQ-020.
- Undefined: any debounced press in CRUISE SHALL go to HALT; BACKUP, SPIN and PUSH are unreachable, and nav_state never shows 1..3.

Verification (defaults, CART_NAV_ESCAPE_EN defined unless noted)
REQ-027 The bench SHALL cover: reset, then ls=5, rs=2 -> lwa=001, rwa=010 one edge later; then ls=rs=0 -> both 001.
REQ-028 The bench SHALL cover: fb held low -> nav_state=1 and both 100 on the 5th edge, bump_evt high 1 cycle; 8 cycles later nav_state=2 with lwa=010, rwa=100 for 8 cycles; then CRUISE.
REQ-029 The bench SHALL cover: lb low for 3 cycles, then high -> no state change; rb low for 4+ cycles -> BACKUP, then SPIN with lwa=100, rwa=010.
REQ-030 The bench SHALL cover: fb and bb low together -> HALT with both 001; release one -> stays HALT; release both -> CRUISE next edge.
REQ-031 The bench SHALL cover: reset pulsed in the 3rd SPIN cycle -> next edge nav_state=0, lwa=rwa=001; no SPIN resumption.
REQ-032 The bench SHALL cover, with the macro undefined: bb low 4+ cycles -> HALT (nav_state=4), never PUSH.
